// File: rtl/x_pe.sv
// Post-processing element for 32 lanes of 16-bit partial sums.
// Accumulates beats, then bias or pooling, ReLU, shift/round and int8 saturation.
module x_pe (
    input  logic         clk,
    input  logic         rst,
    input  logic         calculate_enble,
    input  logic         i_sorter_op,
    input  logic [3:0]   mode,
    input  logic [1:0]   xpe_mode,
    input  logic [4:0]   part_num,
    input  logic [7:0]   out_piece,
    input  logic [7:0]   addr_start_b,
    input  logic [3:0]   i_q_encode,
    input  logic [3:0]   w_q_encode,
    input  logic [3:0]   o_q_encode,
    input  logic [7:0]   avg_pooling_coe,
    input  logic [511:0] npe_data_out,
    input  logic         npe_data_valid,
    input  logic         pe_out_en,
    input  logic [511:0] bias_data,
    input  logic         bias_data_valid,
    input  logic         calculate_end,
    output logic [7:0]   o_b_addr,
    output logic         o_rd_en,
    output logic [255:0] o_xpe_data_out,
    output logic         o_xpe_data_valid,
    output logic [511:0] o_relu_out,
    output logic [511:0] o_final_round,
    output logic [255:0] o_round_out
);
    // state   | meaning
    // ST_IDLE | waiting for calculate_enble, npe beats ignored
    // ST_RUN  | accepting npe beats for the current layer

    localparam int LANES = 32;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t state, state_nxt;
    logic   run;
    logic   start;

    logic signed [23:0] acc [LANES];
    logic signed [23:0] sum [LANES];
    logic signed [31:0] s2  [LANES];
    logic signed [39:0] s3  [LANES];
    logic [4:0]   beat_cnt;
    logic [4:0]   part_eff;
    logic [5:0]   beat_inc;
    logic         beat_take;
    logic         flush;
    logic         relu_en;
    logic         v1, v2;
    logic [511:0] bias_q;
    logic signed [6:0] shift_s;
    logic [7:0]   piece;
    logic [7:0]   piece_eff;
    logic [8:0]   piece_inc;
    logic         unused_mode_bits;

    assign unused_mode_bits = ^mode[3:1];

    function automatic logic signed [31:0] lane_stage1(
        input logic signed [23:0] s,
        input logic [15:0]        b,
        input logic [1:0]         xm,
        input logic [7:0]         coe,
        input logic               relu
    );
        logic signed [31:0] v;
        logic signed [40:0] prod;
        prod = $signed({{17{s[23]}}, s}) * $signed({33'd0, coe});
        case (xm)
            2'd2:    v = {{8{s[23]}}, s} + {{16{b[15]}}, b};
            2'd3:    v = 32'(prod >>> 8);
            default: v = {{8{s[23]}}, s};
        endcase
        if (relu && v[31]) v = '0;
        return v;
    endfunction

    // Left shifts are capped at 8; anything larger saturates anyway.
    function automatic logic signed [39:0] shift_round(
        input logic signed [31:0] v,
        input logic signed [6:0]  s,
        input logic               bypass
    );
        logic signed [39:0] x;
        logic signed [39:0] half;
        logic signed [6:0]  ns;
        x    = {{8{v[31]}}, v};
        ns   = -s;
        half = 40'sd1 <<< (s - 7'sd1);
        if (bypass)              x = x;
        else if (s > 7'sd0)      x = (x + half) >>> s;
        else if (ns > 7'sd8)     x = x <<< 8;
        else                     x = x <<< ns;
        return x;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [39:0] x);
        if (x > 40'sd127)       return 8'h7f;
        else if (x < -40'sd128) return 8'h80;
        else                    return x[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (calculate_end)        state_nxt = ST_IDLE;
        else if (calculate_enble) state_nxt = ST_RUN;
    end

    always_comb begin
        run = (state == ST_RUN);
    end

    assign start     = calculate_enble && !calculate_end;
    assign part_eff  = (part_num == 5'd0) ? 5'd1 : part_num;
    assign beat_inc  = {1'b0, beat_cnt} + 6'd1;
    assign beat_take = run && npe_data_valid;
    assign flush     = run && ((beat_take && (beat_inc >= {1'b0, part_eff} || pe_out_en)) ||
                               (!npe_data_valid && pe_out_en && beat_cnt != 5'd0));
    assign relu_en   = mode[0] && !i_sorter_op && (xpe_mode != 2'd0);
    assign shift_s   = $signed({3'b000, i_q_encode}) + $signed({3'b000, w_q_encode})
                     - $signed({3'b000, o_q_encode});

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sum[k] = acc[k] + (beat_take ? {{8{npe_data_out[16*k+15]}}, npe_data_out[16*k +: 16]}
                                         : 24'sd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
            beat_cnt <= '0;
        end else if (start || flush) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
            beat_cnt <= '0;
        end else if (beat_take) begin
            for (int k = 0; k < LANES; k++) acc[k] <= sum[k];
            beat_cnt <= beat_inc[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bias_q <= '0;
        else if (bias_data_valid) bias_q <= bias_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            o_xpe_data_valid <= 1'b0;
            o_xpe_data_out   <= '0;
            for (int k = 0; k < LANES; k++) begin
                s2[k] <= '0;
                s3[k] <= '0;
            end
        end else begin
            v1 <= flush;
            v2 <= v1;
            o_xpe_data_valid <= v2;
            for (int k = 0; k < LANES; k++) begin
                if (flush)
                    s2[k] <= lane_stage1(sum[k], bias_q[16*k +: 16], xpe_mode,
                                         avg_pooling_coe, relu_en);
                if (v1)
                    s3[k] <= shift_round(s2[k], shift_s, xpe_mode == 2'd0);
                if (v2)
                    o_xpe_data_out[8*k +: 8] <= sat8(s3[k]);
            end
        end
    end

    always_comb begin
        o_relu_out    = '0;
        o_final_round = '0;
        for (int k = 0; k < LANES; k++) begin
            o_relu_out[16*k +: 16]    = s2[k][15:0];
            o_final_round[16*k +: 16] = s3[k][15:0];
        end
    end

    assign o_round_out = o_xpe_data_out;

    // Bias address walks one piece per emitted result and wraps at out_piece.
    assign piece_eff = (out_piece == 8'd0) ? 8'd1 : out_piece;
    assign piece_inc = {1'b0, piece} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piece    <= '0;
            o_b_addr <= '0;
            o_rd_en  <= 1'b0;
        end else begin
            o_rd_en <= 1'b0;
            if (start) begin
                piece    <= '0;
                o_b_addr <= addr_start_b;
                o_rd_en  <= (xpe_mode == 2'd2);
            end else if (o_xpe_data_valid && xpe_mode == 2'd2) begin
                o_rd_en <= 1'b1;
                if (piece_inc >= {1'b0, piece_eff}) begin
                    piece    <= '0;
                    o_b_addr <= addr_start_b;
                end else begin
                    piece    <= piece_inc[7:0];
                    o_b_addr <= addr_start_b + piece_inc[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_x_pe.sv
// Scoreboard bench for x_pe: expected int8 results are queued as beats are driven
// and compared, with their arrival cycle, when o_xpe_data_valid fires.
module tb_x_pe;
    logic         clk = 1'b0;
    logic         rst;
    logic         calculate_enble;
    logic         i_sorter_op;
    logic [3:0]   mode;
    logic [1:0]   xpe_mode;
    logic [4:0]   part_num;
    logic [7:0]   out_piece;
    logic [7:0]   addr_start_b;
    logic [3:0]   i_q_encode, w_q_encode, o_q_encode;
    logic [7:0]   avg_pooling_coe;
    logic [511:0] npe_data_out;
    logic         npe_data_valid;
    logic         pe_out_en;
    logic [511:0] bias_data;
    logic         bias_data_valid;
    logic         calculate_end;
    logic [7:0]   o_b_addr;
    logic         o_rd_en;
    logic [255:0] o_xpe_data_out;
    logic         o_xpe_data_valid;
    logic [511:0] o_relu_out;
    logic [511:0] o_final_round;
    logic [255:0] o_round_out;

    x_pe dut (
        .clk(clk), .rst(rst), .calculate_enble(calculate_enble), .i_sorter_op(i_sorter_op),
        .mode(mode), .xpe_mode(xpe_mode), .part_num(part_num), .out_piece(out_piece),
        .addr_start_b(addr_start_b), .i_q_encode(i_q_encode), .w_q_encode(w_q_encode),
        .o_q_encode(o_q_encode), .avg_pooling_coe(avg_pooling_coe),
        .npe_data_out(npe_data_out), .npe_data_valid(npe_data_valid), .pe_out_en(pe_out_en),
        .bias_data(bias_data), .bias_data_valid(bias_data_valid), .calculate_end(calculate_end),
        .o_b_addr(o_b_addr), .o_rd_en(o_rd_en), .o_xpe_data_out(o_xpe_data_out),
        .o_xpe_data_valid(o_xpe_data_valid), .o_relu_out(o_relu_out),
        .o_final_round(o_final_round), .o_round_out(o_round_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   rd_addr_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_xpe_data_valid) begin
                n_valid++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", o_xpe_data_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("data", o_xpe_data_out, mon_e.data);
                    check("round_out", o_round_out, mon_e.data);
                    check("latency", cyc, mon_e.cyc);
                end
            end
            if (o_rd_en) rd_addr_q.push_back(int'(o_b_addr));
        end
    end

    function automatic logic [511:0] lane16(input int k, input int v);
        logic [511:0] r;
        r = '0;
        r[16*k +: 16] = v[15:0];
        return r;
    endfunction

    function automatic logic [255:0] lane8(input int k, input int v);
        logic [255:0] r;
        r = '0;
        r[8*k +: 8] = v[7:0];
        return r;
    endfunction

    function automatic int sat(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input logic [1:0] xm, input logic [3:0] md, input logic [4:0] pn,
                       input logic [3:0] iq, input logic [3:0] wq, input logic [3:0] oq);
        xpe_mode = xm; mode = md; part_num = pn;
        i_q_encode = iq; w_q_encode = wq; o_q_encode = oq;
    endtask

    task automatic start();
        calculate_enble = 1'b1;
        tick();
        calculate_enble = 1'b0;
    endtask

    task automatic beat(input logic [511:0] d, input logic fl, input logic do_push,
                        input logic [255:0] e);
        npe_data_out = d; npe_data_valid = 1'b1; pe_out_en = fl;
        if (do_push) sb.push_back('{e, cyc + 3});
        tick();
        npe_data_out = '0; npe_data_valid = 1'b0; pe_out_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drain", sb.size(), 0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [255:0] e;
        int v, snap;

        rst = 1'b1; calculate_enble = 0; i_sorter_op = 0; mode = 0; xpe_mode = 0;
        part_num = 0; out_piece = 0; addr_start_b = 0; i_q_encode = 0; w_q_encode = 0;
        o_q_encode = 0; avg_pooling_coe = 0; npe_data_out = '0; npe_data_valid = 0;
        pe_out_en = 0; bias_data = '0; bias_data_valid = 0; calculate_end = 0;
        idle(3);
        check("rst_valid", o_xpe_data_valid, 0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_addr", o_b_addr, 0);
        check("rst_data", o_xpe_data_out, 0);
        check("rst_relu", |o_relu_out, 0);
        check("rst_final", |o_final_round, 0);
        rst = 1'b0;
        tick();

        // ReLU on, s=1: 3,5,7 -> 2,3,4 on consecutive cycles
        cfg(2'd1, 4'd3, 5'd1, 4'd1, 4'd1, 4'd1);
        start();
        beat(lane16(0, 3), 0, 1, lane8(0, 2));
        beat(lane16(0, 5), 0, 1, lane8(0, 3));
        beat(lane16(0, 7), 0, 1, lane8(0, 4));
        drain();

        // three-beat accumulation, s=0
        cfg(2'd1, 4'd0, 5'd3, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(0, 10), 0, 0, '0);
        beat(lane16(0, 20), 0, 0, '0);
        beat(lane16(0, 30), 0, 1, lane8(0, 60));
        drain();

        // ReLU and sorter bypass
        cfg(2'd1, 4'd1, 5'd1, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(0, -50), 0, 1, lane8(0, 0));
        drain();
        i_sorter_op = 1'b1;
        beat(lane16(0, -50), 0, 1, lane8(0, 8'hce));
        drain();
        i_sorter_op = 1'b0;

        // saturation in two lanes of one beat
        cfg(2'd1, 4'd0, 5'd1, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(3, 300) | lane16(7, -300), 0, 1, lane8(3, 127) | lane8(7, -128));
        drain();

        // all lanes, s=2 round half up then saturate
        cfg(2'd1, 4'd0, 5'd1, 4'd2, 4'd1, 4'd1);
        start();
        for (int b = 0; b < 4; b++) begin
            d = '0; e = '0;
            for (int k = 0; k < 32; k++) begin
                v = int'($urandom_range(2000)) - 1000;
                d = d | lane16(k, v);
                e = e | lane8(k, sat((v + 2) >>> 2));
            end
            beat(d, 0, 1, e);
        end
        drain();

        // pe_out_en flushes before part_num is reached
        cfg(2'd1, 4'd0, 5'd4, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(2, 7), 0, 0, '0);
        beat(lane16(2, 8), 1, 1, lane8(2, 15));
        drain();

        // bias mode with address walk 5,6,5
        bias_data = lane16(0, 4); bias_data_valid = 1'b1;
        tick();
        bias_data_valid = 1'b0;
        out_piece = 8'd2; addr_start_b = 8'd5;
        cfg(2'd2, 4'd0, 5'd1, 4'd0, 4'd0, 4'd0);
        rd_addr_q.delete();
        start();
        beat(lane16(0, 6), 0, 1, lane8(0, 10));
        beat(lane16(0, 6), 0, 1, lane8(0, 10));
        drain();
        idle(2);
        check("rd_count", rd_addr_q.size(), 3);
        check("rd_addr0", rd_addr_q.size() > 0 ? rd_addr_q[0] : -1, 5);
        check("rd_addr1", rd_addr_q.size() > 1 ? rd_addr_q[1] : -1, 6);
        check("rd_addr2", rd_addr_q.size() > 2 ? rd_addr_q[2] : -1, 5);

        // average pooling by 0.5, floor on negatives
        avg_pooling_coe = 8'd128;
        cfg(2'd3, 4'd0, 5'd1, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(0, 10) | lane16(1, -7), 0, 1, lane8(0, 5) | lane8(1, -4));
        drain();

        // pass-through ignores shift and ReLU
        cfg(2'd0, 4'd1, 5'd1, 4'd3, 4'd0, 4'd1);
        start();
        beat(lane16(4, -20), 0, 1, lane8(4, -20));
        drain();

        // calculate_end returns to idle; beats then ignored
        cfg(2'd1, 4'd0, 5'd1, 4'd0, 4'd0, 4'd0);
        start();
        calculate_end = 1'b1;
        tick();
        calculate_end = 1'b0;
        snap = n_valid;
        beat(lane16(0, 9), 0, 0, '0);
        idle(6);
        check("idle_ignores_beat", n_valid - snap, 0);

        // reset in the middle of a 3-beat accumulation
        cfg(2'd2, 4'd0, 5'd3, 4'd0, 4'd0, 4'd0);
        start();
        beat(lane16(0, 1), 0, 0, '0);
        beat(lane16(0, 2), 0, 0, '0);
        rst = 1'b1;
        #1;
        check("midrst_valid", o_xpe_data_valid, 0);
        check("midrst_rd_en", o_rd_en, 0);
        check("midrst_addr", o_b_addr, 0);
        check("midrst_relu", |o_relu_out, 0);
        check("midrst_final", |o_final_round, 0);
        check("midrst_data", o_xpe_data_out, 0);
        tick();
        rst = 1'b0;
        snap = n_valid;
        beat(lane16(0, 3), 0, 0, '0);
        idle(8);
        check("no_valid_after_rst", n_valid - snap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/x_pe.md
X_PE -- requirements
Module: x_pe

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous reset, active-high.
REQ-003 calculate_enble  in  1  one-cycle start pulse for a layer.
REQ-004 i_sorter_op  in  1  1 = sorter op; ReLU bypassed.
REQ-005 mode  in  4  bit0 = ReLU enable; bits 3:1 ignored.
REQ-006 xpe_mode  in  2  0 pass-through, 1 accumulate+quantize, 2 accumulate+bias+quantize, 3 average pool.
REQ-007 part_num  in  5  beats accumulated per output; 0 treated as 1.
REQ-008 out_piece  in  8  output pieces per bias cycle; 0 treated as 1.
REQ-009 addr_start_b  in  8  first bias buffer address.
REQ-010 i_q_encode, w_q_encode, o_q_encode  in  4 each  fractional bits of input, weight and output.
REQ-011 avg_pooling_coe  in  8  pooling multiplier, unsigned Q0.8.
REQ-012 npe_data_out  in  512  32 lanes x signed 16-bit partial sums; lane k = bits [16k+15:16k].
REQ-013 npe_data_valid  in  1  npe_data_out valid this cycle.
REQ-014 pe_out_en  in  1  force flush of the current accumulation.
REQ-015 bias_data  in  512  32 lanes x signed 16-bit bias.
REQ-016 bias_data_valid  in  1  bias_data valid this cycle.
REQ-017 calculate_end  in  1  layer done; return to idle.
REQ-018 o_b_addr  out  8  bias read address.
REQ-019 o_rd_en  out  1  one-cycle bias read strobe.
REQ-020 o_xpe_data_out  out  256  32 lanes x signed int8 result.
REQ-021 o_xpe_data_valid  out  1  one-cycle result strobe.
REQ-022 o_relu_out  out  512  32 x 16-bit stage-2 tap (after ReLU).
REQ-023 o_final_round  out  512  32 x 16-bit stage-3 tap (after shift and round, before saturation).
REQ-024 o_round_out  out  256  32 x int8 saturated values; equal to o_xpe_data_out.

Function
REQ-025 States: IDLE and RUN. calculate_enble moves the block to RUN. calculate_end returns it to IDLE and has priority over calculate_enble in the same cycle.
- On calculate_enble, clear the accumulator, beat counter and piece counter, and set o_b_addr = addr_start_b.
- If xpe_mode=2, assert o_rd_en for 1 cycle.
REQ-026 Stage 1: each cycle with npe_data_valid in RUN adds every lane, sign-extended, into a 24-bit per-lane accumulator.
- When the beat count reaches part_num, or when pe_out_en=1 with at least one beat taken, the result (current accumulator plus current beat) moves to stage 2.
- The accumulator and beat counter then clear.
REQ-027 Per-mode handling of the stage-1 result:
- xpe_mode=2: add the latched bias lane. Bias is latched on bias_data_valid.
- xpe_mode=3: multiply by avg_pooling_coe, then shift right arithmetically by 8.
- xpe_mode=0: forward the lane value unchanged; no shift, no ReLU.
REQ-028 Stage 2: if mode[0]=1 and i_sorter_op=0, negative lanes become 0. Register the result; o_relu_out shows its low 16 bits per lane.
REQ-029 Stage 3 shift: s = i_q_encode + w_q_encode - o_q_encode, computed signed.
- s>0: arithmetic right shift by s, round half up (add 2^(s-1) first).
- s<=0: left shift by -s, capped at 8.
- Register the result; o_final_round shows its low 16 bits.
REQ-030 Saturate each lane to [-128,127] and register it to o_xpe_data_out / o_round_out. Assert o_xpe_data_valid for one cycle.
- Latency from a completing npe beat to o_xpe_data_valid is exactly 3 cycles. Fully pipelined, one result per cycle.
REQ-031 After each emitted result in xpe_mode=2:
- Increment the piece counter and set o_b_addr = addr_start_b + piece.
- When piece reaches out_piece, wrap to 0 and set o_b_addr = addr_start_b.
- Pulse o_rd_en once for the new address.
REQ-032 Outside RUN, npe_data_valid is ignored. Pipeline contents already in flight still drain.

Reset
REQ-033 While rst=1: state IDLE; every counter, accumulator and pipeline register at 0; every output at 0, including o_xpe_data_valid and o_rd_en.
REQ-034 Reset asserted mid-operation discards all in-flight data. No o_xpe_data_valid appears until a new calculate_enble and new data.

Verification
REQ-035 mode=3, xpe_mode=1, part_num=1, q encodes 1/1/1. calculate_enble pulse, then lane0 beats 3, 5, 7 on consecutive cycles -> o_xpe_data_out lane0 = 2, 3, 4 (other lanes 0), valid on 3 consecutive cycles, 3 cycles after each beat.
REQ-036 part_num=3, lane0 beats 10, 20, 30, shift s=0 -> a single result, lane0 = 60.
REQ-037 Lane value -50 with mode[0]=1 -> 0. Same value with i_sorter_op=1 -> -50 (0xCE).
REQ-038 s=0, lane value 300 -> 127. Lane value -300 -> -128.
REQ-039 xpe_mode=2, out_piece=2, addr_start_b=5 -> o_b_addr 5, 6, 5 and o_rd_en pulses at start and after each result. Bias 4 plus beat 6, s=0 -> 10.
REQ-040 rst pulsed during a 3-beat accumulation -> all outputs 0 and no valid pulse afterwards.
